// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph codes for the
// non-hex symbols and the active-low segment bus layout.
package sev_seg_pkg;

    typedef logic [4:0] glyph_code_t;
    typedef logic [7:0] seg_t;

    // Glyph codes beyond the hex range 0..15
    localparam glyph_code_t GLY_L     = 5'd16;
    localparam glyph_code_t GLY_R     = 5'd17;
    localparam glyph_code_t GLY_DASH  = 5'd18;
    localparam glyph_code_t GLY_BLANK = 5'd19;

    // Segment bus is {dp,g,f,e,d,c,b,a}, active-low
    localparam seg_t SEG_BLANK  = 8'hFF;
    localparam int   SEG_DP_BIT = 7;

endpackage

// File: rtl/sev_seg_glyph.sv
// Combinational glyph table: 5-bit code to active-low segment pattern with
// the decimal point off. Codes 19..31 are blank.
module sev_seg_glyph
    import sev_seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [7:0] seg
);

    // Table lookup; unlisted codes fall through to blank
    always_comb begin
        // NOTE: default assigned first so no path leaves seg unassigned (no latch).
        seg = SEG_BLANK;
        case (code)
            5'd0:      seg = 8'hC0;
            5'd1:      seg = 8'hF9;
            5'd2:      seg = 8'hA4;
            5'd3:      seg = 8'hB0;
            5'd4:      seg = 8'h99;
            5'd5:      seg = 8'h92;
            5'd6:      seg = 8'h82;
            5'd7:      seg = 8'hF8;
            5'd8:      seg = 8'h80;
            5'd9:      seg = 8'h90;
            5'd10:     seg = 8'h88;
            5'd11:     seg = 8'h83;
            5'd12:     seg = 8'hC6;
            5'd13:     seg = 8'hA1;
            5'd14:     seg = 8'h86;
            5'd15:     seg = 8'h8E;
            GLY_L:     seg = 8'hC7;
            GLY_R:     seg = 8'hAF;
            GLY_DASH:  seg = 8'hBF;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed multi-digit seven-segment driver. Each digit slot lasts
// REFRESH_DIV cycles, the first of which is blanked to stop ghosting. Inputs
// are captured once per frame so a frame never mixes old and new values.
module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [5*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [7:0]              display,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef logic [PW-1:0] pre_t;
    typedef logic [IW-1:0] idx_t;
    typedef logic [BW-1:0] blk_t;

    localparam pre_t P_LAST = pre_t'(REFRESH_DIV - 1);
    localparam idx_t I_LAST = idx_t'(NUM_DIGITS - 1);
    localparam blk_t B_LAST = blk_t'(BLINK_DIV - 1);

    pre_t        p;
    idx_t        i;
    blk_t        bcnt;
    logic        blink_phase;

    glyph_code_t shadow_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] shadow_blink;

    logic        p_wrap;
    logic        frame_wrap;
    logic        frame_start;
    glyph_code_t code_sel;
    seg_t        glyph_seg;
    seg_t        display_next;
    logic [NUM_DIGITS-1:0] anode_next;

    assign p_wrap      = (p == P_LAST);
    assign frame_wrap  = p_wrap && (i == I_LAST);
    assign frame_start = (p == '0) && (i == '0);

    // Prescaler, digit index and blink counters; all parked at 0 while disabled
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            p           <= '0;
            i           <= '0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (!enable) begin
            p           <= '0;
            i           <= '0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (p_wrap) begin
                p <= '0;
                i <= (i == I_LAST) ? '0 : i + 1'b1;
            end else begin
                p <= p + 1'b1;
            end
            if (frame_wrap) begin
                if (bcnt == B_LAST) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

    // Frame-coherent capture of the digit inputs at the start of each frame
    always_ff @(posedge clk) begin
        // NOTE: the shadow bank is a handful of flops, not a RAM, so it is reset to a known blank.
        if (reset) begin
            for (int d = 0; d < NUM_DIGITS; d++) shadow_code[d] <= GLY_BLANK;
            shadow_dp    <= '0;
            shadow_blink <= '0;
        end else if (frame_start) begin
            for (int d = 0; d < NUM_DIGITS; d++) shadow_code[d] <= codes[5*d +: 5];
            shadow_dp    <= dp_in;
            shadow_blink <= blink_en;
        end
    end

    assign code_sel = shadow_code[i];

    sev_seg_glyph u_glyph (
        .code (code_sel),
        .seg  (glyph_seg)
    );

    // Next output pattern: blank slot start, otherwise the selected digit
    always_comb begin
        anode_next   = '1;
        display_next = SEG_BLANK;
        if (enable && (p != '0)) begin
            for (int d = 0; d < NUM_DIGITS; d++) anode_next[d] = (idx_t'(d) != i);
            display_next = glyph_seg;
            if (shadow_dp[i]) display_next[SEG_DP_BIT] = 1'b0;
            // Blinked-off digits keep their anode driven but show nothing
            if (shadow_blink[i] && blink_phase) display_next = SEG_BLANK;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            display    <= SEG_BLANK;
            anode      <= '1;
            frame_tick <= 1'b0;
        end else begin
            display    <= display_next;
            anode      <= anode_next;
            frame_tick <= enable && frame_wrap;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Scoreboard bench for sev_seg_scan (4 digits, 4-cycle slots, 2-frame blink).
// The driver pushes expected outputs tagged with the clock edge they belong
// to; the monitor compares the outputs after every edge against the queue.
module tb_sev_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [19:0] codes;
    logic [3:0]  dp_in;
    logic [3:0]  blink_en;
    logic [7:0]  display;
    logic [3:0]  anode;
    logic        frame_tick;

    sev_seg_scan #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_DIV   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .codes      (codes),
        .dp_in      (dp_in),
        .blink_en   (blink_en),
        .display    (display),
        .anode      (anode),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] anode;
        logic [7:0] display;
        logic       ft;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int edge_no,
                         input logic [12:0] got, input logic [12:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got anode=%b display=%h tick=%b, expected anode=%b display=%h tick=%b",
                     name, edge_no, got[12:9], got[8:1], got[0], want[12:9], want[8:1], want[0]);
        end
    endtask

    // Monitor: after each edge, compare every expectation tagged for it
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for edge %0d skipped at edge %0d", mon_e.name, mon_e.cyc, cyc);
            end else begin
                check(mon_e.name, cyc, {anode, display, frame_tick},
                      {mon_e.anode, mon_e.display, mon_e.ft});
            end
        end
    end

    task automatic push(input int c, input logic [3:0] an, input logic [7:0] d,
                        input logic ft, input string nm);
        exp_t e;
        e.cyc = c; e.anode = an; e.display = d; e.ft = ft; e.name = nm;
        sb.push_back(e);
    endtask

    // Expected frame starting with the digit-0 blank cycle at edge f0;
    // segs = {d3,d2,d1,d0}; only the first n edges of the frame are pushed
    task automatic push_frame(input int f0, input logic [31:0] segs, input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            int s;
            s = k / 4;
            if (k % 4 == 0) push(f0 + k, 4'hF, 8'hFF, 1'b0, nm);
            else            push(f0 + k, ~(4'b0001 << s), segs[8*s +: 8], (k == 15), nm);
        end
    endtask

    // Wait for the falling edge after rising edge number k
    task automatic goto(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    localparam logic [31:0] SEGS_DEC   = {8'hC7, 8'hAF, 8'h3F, 8'h92};
    localparam logic [31:0] SEGS_TEAR  = {8'hC7, 8'h80, 8'h3F, 8'h92};
    localparam logic [31:0] SEGS_BLINK = {8'hC7, 8'h80, 8'hFF, 8'h92};
    localparam logic [31:0] SEGS_NONE  = 32'hFFFF_FFFF;
    localparam logic [31:0] SEGS_HEX   = {8'hC0, 8'hF9, 8'hA4, 8'hB0};
    localparam logic [31:0] SEGS_HEXB  = {8'hFF, 8'hF9, 8'hA4, 8'hB0};

    initial begin
        // Reset held for three edges with enable high; inputs already set
        reset    = 1'b1;
        enable   = 1'b1;
        codes    = {5'd16, 5'd17, 5'd18, 5'd5};
        dp_in    = 4'b0010;
        blink_en = 4'b0000;
        for (int k = 1; k <= 3; k++) push(k, 4'hF, 8'hFF, 1'b0, "reset");

        goto(3);
        reset = 1'b0;
        push_frame(4,   SEGS_DEC,   16, "decode_f0");
        push_frame(20,  SEGS_TEAR,  16, "tear_f1");
        push_frame(36,  SEGS_BLINK, 16, "blink_f2");
        push_frame(52,  SEGS_BLINK, 16, "blink_f3");
        push_frame(68,  SEGS_NONE,  16, "blank_20_23");
        push_frame(84,  SEGS_NONE,  16, "blank_24_27");
        push_frame(100, SEGS_NONE,  16, "blank_28_31");

        // Digit-1 slot of frame 0: change d2 and arm blink for the next frame
        goto(9);
        codes[14:10] = 5'd8;
        blink_en     = 4'b0010;

        // Frames 3..6: feed the undefined codes, one frame at a time
        goto(54);
        codes = {5'd23, 5'd22, 5'd21, 5'd20};
        dp_in = 4'b0000;
        blink_en = 4'b0000;
        goto(70);
        codes = {5'd27, 5'd26, 5'd25, 5'd24};
        goto(86);
        codes = {5'd31, 5'd30, 5'd29, 5'd28};
        goto(102);
        codes = {5'd0, 5'd1, 5'd2, 5'd3};
        push_frame(116, SEGS_HEX, 11, "pre_disable");

        // Drop enable in the digit-2 slot, hold three edges, then resume
        goto(126);
        enable   = 1'b0;
        blink_en = 4'b1000;
        for (int k = 127; k <= 129; k++) push(k, 4'hF, 8'hFF, 1'b0, "disabled");
        goto(129);
        enable = 1'b1;
        push_frame(130, SEGS_HEX,  16, "reenable_f0");
        push_frame(146, SEGS_HEX,  16, "reenable_f1");
        push_frame(162, SEGS_HEXB, 14, "blink_d3");

        // Reset while digit 3 is blinked off, then check phase restarts at 0
        goto(175);
        reset = 1'b1;
        push(176, 4'hF, 8'hFF, 1'b0, "midslot_reset");
        push(177, 4'hF, 8'hFF, 1'b0, "midslot_reset");
        goto(177);
        reset = 1'b0;
        push_frame(178, SEGS_HEX, 16, "after_reset");

        goto(196);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sev_seg_scan.md
Name: sev_seg_scan

Overview:
Parametrised multi-digit, time-multiplexed seven-segment driver; successor to the single-digit combinational decoders.
- Scans NUM_DIGITS common-anode digits from one 8-bit segment bus.
- Decodes a 5-bit glyph code per digit: hex, L, r, dash, blank.
- Adds per-digit decimal point, per-digit blink and frame-coherent input capture.
- Sits between the turn-signal/state logic and the board display pins.

Parameters:
NUM_DIGITS, 4, digits scanned; legal 1..8
REFRESH_DIV, 50000, clk cycles per digit slot; legal >=2
BLINK_DIV, 25, frames per blink half-period; legal >=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1=scan, 0=display dark
codes  in  5*NUM_DIGITS  glyph code; digit i uses codes[5*i+4:5*i]
dp_in  in  NUM_DIGITS  1=light decimal point of digit i
blink_en  in  NUM_DIGITS  1=digit i blinks
display  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
anode  out  NUM_DIGITS  digit enables, active-low; bit i = digit i
frame_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on port reset. All outputs are registered.
- Reset values:
  - display=8'hFF, anode=all 1s, frame_tick=0.
  - Prescaler p=0, digit index i=0, blink counter=0, blink_phase=0.
  - Shadow codes=blank (19), shadow dp/blink=0.
- Counters, advancing only while enable=1:
  - p counts 0..REFRESH_DIV-1 and wraps to 0.
  - On p wrap, i advances and wraps NUM_DIGITS-1 -> 0.
  - On i wrap (with p wrap), frame_tick=1 on the next cycle. The blink counter counts frames 0..BLINK_DIV-1; on its wrap blink_phase toggles.
  - p width is clog2(REFRESH_DIV). i width is max(1, clog2(NUM_DIGITS)).
- Shadow capture:
  - codes, dp_in and blink_en are copied to shadow registers in every cycle where p==0 and i==0.
  - Mid-frame input changes are not displayed until the next frame start, so there is no tearing.
- Output pipeline, one-cycle latency from state (p,i):
  - p==0, the anti-ghost blank cycle: anode=all 1s, display=8'hFF.
  - p!=0: anode has only bit i low. display = glyph(shadow code i), with bit7 cleared if shadow dp[i]=1.
  - If shadow blink[i]=1 and blink_phase=1: display=8'hFF and the anode stays driven.
- Glyph table (active-low, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - 10 A=88, 11 b=83, 12 C=C6, 13 d=A1, 14 E=86, 15 F=8E.
  - 16 L=C7, 17 r=AF, 18 dash=BF, 19..31 blank=FF.
- enable=0:
  - Next cycle: anode all 1s, display=FF, frame_tick=0.
  - p, i, blink counter and blink_phase are held at 0. Shadow keeps loading, since p==0 and i==0.
  - When enable rises, the scan restarts at digit 0 with a blank cycle.
- reset has priority over enable. Reset mid-frame returns to reset values on the next edge with no partial-slot output.
- NUM_DIGITS=1: i is constant 0 and frame_tick pulses on every p wrap.

Decomposition:
- Shared package/include sev_seg_pkg holds:
  - Glyph code constants GLY_L=16, GLY_R=17, GLY_DASH=18, GLY_BLANK=19.
  - Segment constants SEG_BLANK=8'hFF and the dp bit index 7.
- One natural sub-module: sev_seg_glyph, a combinational 5-bit code -> 8-bit active-low pattern table, instantiated once on the selected shadow code.
- Counters, shadow registers and output registers stay in sev_seg_scan.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2.
1. Reset: hold reset 3 cycles with enable=1 -> anode=1111, display=FF, frame_tick=0. After release: one blank cycle, then anode=1110 for 3 cycles, one blank, then anode=1101; frame_tick pulses every 16 cycles.
2. Decode: codes={d3=L, d2=r, d1=dash, d0=5}, dp_in=0010 -> slot outputs d0=92, d1=3F (BF with dp lit), d2=AF, d3=C7; codes 20..31 all give FF.
3. Tearing: change d2 from r to 8 during the digit-1 slot -> d2 still shows AF this frame and 80 from the next frame.
4. Blink: blink_en=0010 -> digit 1 visible in frames 0-1, FF in frames 2-3 while anode=1101 stays driven; other digits unaffected.
5. Enable: drop enable in the digit-2 slot -> next cycle anode=1111, display=FF, counters 0. Re-enable -> blank cycle then anode=1110.
6. Reset mid-slot on digit 3 with blink_phase=1 -> next edge gives reset values; blink_phase=0 and shadow=blank until the first frame capture.
